// File: rtl/fcbt_result_sink.sv
`default_nettype none
// ============================================================================
//  Module   : fcbt_result_sink
//  Purpose  : Result consumer for the FCBT accumulator. Each completed group
//             sum is captured into a small first-word-fall-through FIFO and
//             tagged with a wrapping group index. Results leave through a
//             valid/ready interface. When the FIFO is full, hold_output
//             back-pressures the accumulator so that no result is lost.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             out, valid_out    - accumulator group sum and its valid pulse
//             hold_output       - registered stall request to the accumulator
//             res_data/res_index- head-of-FIFO sum and its group index
//             res_valid/res_ready - downstream handshake
//             count             - entries currently held
//             groups_total      - results accepted since reset (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module fcbt_result_sink #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,   // power of two, >= 2
  parameter int IDX_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           out,
  input  logic                       valid_out,
  output logic                       hold_output,
  output logic [WIDTH-1:0]           res_data,
  output logic [IDX_WIDTH-1:0]       res_index,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                groups_total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0]     data_mem [DEPTH];
  logic [IDX_WIDTH-1:0] idx_mem  [DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [IDX_WIDTH-1:0] next_index;
  logic [CNT_W-1:0]     count_next;
  logic                 accept;
  logic                 drain;

  // hold_output mirrors (count == DEPTH), so gating accept with it alone
  // is enough to rule out overflow; res_valid gating rules out underflow.
  assign accept    = valid_out & ~hold_output;
  assign res_valid = (count != '0);
  assign drain     = res_valid & res_ready;

  assign res_data  = data_mem[rd_ptr];
  assign res_index = idx_mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({accept, drain})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;  // idle, or accept+drain cancel out
    endcase
  end

  // Storage carries no reset: contents are don't-care while res_valid=0.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr] <= out;
      idx_mem[wr_ptr]  <= next_index;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      next_index   <= '0;
      count        <= '0;
      hold_output  <= 1'b0;
      groups_total <= '0;
    end else begin
      count       <= count_next;
      // Registered from count_next so the stall is visible in the very
      // cycle after the accept that fills the FIFO.
      hold_output <= (count_next == FULL_COUNT);
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        next_index <= next_index + 1'b1;
        if (groups_total != 32'hFFFF_FFFF) begin
          groups_total <= groups_total + 32'd1;
        end
      end
      if (drain) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fcbt_result_sink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fcbt_result_sink
//  Purpose  : Directed self-checking bench for fcbt_result_sink. A second
//             instance with IDX_WIDTH=2 exercises group-index wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fcbt_result_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance (default parameters)
  logic [31:0] out = '0;
  logic        valid_out = 1'b0;
  logic        res_ready = 1'b0;
  logic        hold_output;
  logic [31:0] res_data;
  logic [7:0]  res_index;
  logic        res_valid;
  logic [3:0]  count;
  logic [31:0] groups_total;

  // Wrap instance (IDX_WIDTH = 2)
  logic [31:0] out_w = '0;
  logic        valid_out_w = 1'b0;
  logic        res_ready_w = 1'b0;
  logic        hold_output_w;
  logic [31:0] res_data_w;
  logic [1:0]  res_index_w;
  logic        res_valid_w;
  logic [3:0]  count_w;
  logic [31:0] groups_total_w;

  int checks = 0;
  int passes = 0;

  fcbt_result_sink #(.WIDTH(32), .DEPTH(8), .IDX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .out(out), .valid_out(valid_out),
    .hold_output(hold_output), .res_data(res_data), .res_index(res_index),
    .res_valid(res_valid), .res_ready(res_ready), .count(count),
    .groups_total(groups_total)
  );

  fcbt_result_sink #(.WIDTH(32), .DEPTH(8), .IDX_WIDTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .out(out_w), .valid_out(valid_out_w),
    .hold_output(hold_output_w), .res_data(res_data_w),
    .res_index(res_index_w), .res_valid(res_valid_w),
    .res_ready(res_ready_w), .count(count_w),
    .groups_total(groups_total_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_out = 1'b0; res_ready = 1'b0;
    valid_out_w = 1'b0; res_ready_w = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_hold", 64'(hold_output), 64'd0);
    check("rst_total", 64'(groups_total), 64'd0);

    // ---------------- single group ----------------
    out = 32'h43A28000; valid_out = 1'b1;
    step();
    valid_out = 1'b0;
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_data", 64'(res_data), 64'h43A28000);
    check("single_index", 64'(res_index), 64'd0);
    check("single_count", 64'(count), 64'd1);
    check("single_total", 64'(groups_total), 64'd1);
    step();
    check("single_hold_stays", 64'(count), 64'd1);

    // ---------------- streaming ----------------
    do_reset();
    res_ready = 1'b1;
    valid_out = 1'b1; out = 32'h41C00000;
    step();
    check("stream0_data", 64'(res_data), 64'h41C00000);
    check("stream0_index", 64'(res_index), 64'd0);
    check("stream0_count", 64'(count), 64'd1);
    out = 32'h40C00000;
    step();
    check("stream1_data", 64'(res_data), 64'h40C00000);
    check("stream1_index", 64'(res_index), 64'd1);
    check("stream1_count", 64'(count), 64'd1);
    out = 32'h40E00000;
    step();
    check("stream2_data", 64'(res_data), 64'h40E00000);
    check("stream2_index", 64'(res_index), 64'd2);
    check("stream2_count", 64'(count), 64'd1);
    valid_out = 1'b0;
    step();
    check("stream_empty", 64'(res_valid), 64'd0);
    check("stream_total", 64'(groups_total), 64'd3);

    // ---------------- fill and back-pressure ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      out = 32'd100 + 32'(i); valid_out = 1'b1;
      step();
      if (i == 6) check("fill7_hold", 64'(hold_output), 64'd0);
    end
    check("fill_count", 64'(count), 64'd8);
    check("fill_hold", 64'(hold_output), 64'd1);
    out = 32'h41100000; valid_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("held_count", 64'(count), 64'd8);
      check("held_hold", 64'(hold_output), 64'd1);
    end
    check("held_total", 64'(groups_total), 64'd8);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("unfull_hold", 64'(hold_output), 64'd0);
    check("unfull_count", 64'(count), 64'd7);
    check("unfull_head", 64'(res_data), 64'd101);
    step();
    valid_out = 1'b0;
    check("ninth_count", 64'(count), 64'd8);
    check("ninth_hold", 64'(hold_output), 64'd1);
    check("ninth_total", 64'(groups_total), 64'd9);
    res_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      check("drain_data", 64'(res_data), 64'd100 + 64'(k));
      check("drain_index", 64'(res_index), 64'(k));
      step();
    end
    check("drain9_data", 64'(res_data), 64'h41100000);
    check("drain9_index", 64'(res_index), 64'd8);
    step();
    res_ready = 1'b0;
    check("drain_empty", 64'(count), 64'd0);
    step();
    res_ready = 1'b1;  // ready while empty must be ignored
    step();
    res_ready = 1'b0;
    check("underflow_count", 64'(count), 64'd0);

    // ---------------- simultaneous accept/drain at count=3 ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      out = 32'd200 + 32'(i); valid_out = 1'b1;
      step();
    end
    check("sim_pre_count", 64'(count), 64'd3);
    out = 32'd203; res_ready = 1'b1;
    step();
    valid_out = 1'b0; res_ready = 1'b0;
    check("sim_count", 64'(count), 64'd3);
    res_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check("sim_order", 64'(res_data), 64'd200 + 64'(k));
      step();
    end
    res_ready = 1'b0;
    check("sim_empty", 64'(res_valid), 64'd0);

    // ---------------- index wrap (IDX_WIDTH = 2) ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      out_w = 32'd300 + 32'(i); valid_out_w = 1'b1;
      step();
    end
    valid_out_w = 1'b0;
    check("wrap_count", 64'(count_w), 64'd6);
    res_ready_w = 1'b1;
    begin
      logic [1:0] exp_idx [6];
      exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int k = 0; k < 6; k++) begin
        check("wrap_index", 64'(res_index_w), 64'(exp_idx[k]));
        check("wrap_data", 64'(res_data_w), 64'd300 + 64'(k));
        step();
      end
    end
    res_ready_w = 1'b0;
    check("wrap_empty", 64'(res_valid_w), 64'd0);

    // ---------------- reset mid-stream ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      out = 32'd400 + 32'(i); valid_out = 1'b1;
      step();
    end
    check("mid_pre_count", 64'(count), 64'd5);
    out = 32'hDEADBEEF; valid_out = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; valid_out = 1'b0;
    check("mid_count", 64'(count), 64'd0);
    check("mid_valid", 64'(res_valid), 64'd0);
    check("mid_hold", 64'(hold_output), 64'd0);
    check("mid_total", 64'(groups_total), 64'd0);
    step();
    check("mid_after_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
